// File: rtl/gf_div6_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | gf6_pkg : shared GF(2^6) constants and divider state encoding          |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

package gf6_pkg;

  localparam int             GF_W    = 6;
  localparam logic [GF_W:0]  GF_POLY = 7'b1000011;  // x^6 + x + 1
  localparam int             N_ITER  = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQR  = 3'd1,
    ST_MUL  = 3'd2,
    ST_FIN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gf_div6_seq_if.sv
// +-----------------------------------------------------------------------+
// | gf_div6_seq_if : operand/result handshake bundle for gf_div6_seq       |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

interface gf_div6_seq_if;

  logic                      in_valid;
  logic                      in_ready;
  logic [gf6_pkg::GF_W-1:0]  in_a;
  logic [gf6_pkg::GF_W-1:0]  in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [gf6_pkg::GF_W-1:0]  out_q;
  logic                      out_dbz;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_dbz
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_dbz
  );

endinterface

`default_nettype wire

// File: rtl/gf_div6_seq_mul6.sv
// +-----------------------------------------------------------------------+
// | gf_mul6 : combinational GF(2^6) multiplier, reduced modulo POLY        |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module gf_mul6
  import gf6_pkg::*;
#(
  parameter logic [GF_W:0] POLY = GF_POLY
) (
  input  logic [GF_W-1:0] a_i,
  input  logic [GF_W-1:0] b_i,
  output logic [GF_W-1:0] p_o
);

  logic [2*GF_W-2:0] prod;

  // Carry-less product first, then fold the high terms down from the top.
  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b_i[i]) prod[i +: GF_W] = prod[i +: GF_W] ^ a_i;
    end
    for (int i = 2*GF_W-2; i >= GF_W; i--) begin
      if (prod[i]) prod[i-GF_W +: GF_W+1] = prod[i-GF_W +: GF_W+1] ^ POLY;
    end
    p_o = prod[GF_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/gf_div6_seq.sv
// +-----------------------------------------------------------------------+
// | gf_div6_seq : sequential GF(2^6) divider, q = a * b^62, one multiplier |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module gf_div6_seq
  import gf6_pkg::*;
#(
  parameter logic [GF_W:0] POLY = GF_POLY
) (
  input  logic            clk,
  input  logic            rst,
  gf_div6_seq_if.slave    bus
);

  state_e            state_q, state_d;
  logic [GF_W-1:0]   a_q, a_d, s_q, s_d, r_q, r_d, q_q, q_d;
  logic [2:0]        k_q, k_d;
  logic              dbz_q, dbz_d;
  logic [GF_W-1:0]   mul_x, mul_y, mul_p;

  gf_mul6 #(.POLY(POLY)) u_mul (
    .a_i (mul_x),
    .b_i (mul_y),
    .p_o (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_q     <= q_d;
      k_q     <= k_d;
      dbz_q   <= dbz_d;
    end
  end

  // Square-and-multiply: after 5 rounds R = b^(2+4+8+16+32) = b^62 = b^-1.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    r_d     = r_q;
    q_d     = q_q;
    k_d     = k_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          s_d     = bus.in_b;
          r_d     = {{(GF_W-1){1'b0}}, 1'b1};
          k_d     = '0;
          dbz_d   = (bus.in_b == '0);
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        s_d     = mul_p;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        r_d     = mul_p;
        k_d     = k_q + 3'd1;
        state_d = (k_q == 3'(N_ITER-1)) ? ST_FIN : ST_SQR;
      end
      ST_FIN: begin
        q_d     = mul_p;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_q     = '0;
    bus.out_dbz   = 1'b0;
    mul_x         = '0;
    mul_y         = '0;
    case (state_q)
      ST_IDLE: bus.in_ready = 1'b1;
      ST_SQR: begin
        mul_x = s_q;
        mul_y = s_q;
      end
      ST_MUL: begin
        mul_x = r_q;
        mul_y = s_q;
      end
      ST_FIN: begin
        mul_x = a_q;
        mul_y = r_q;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_q     = q_q;
        bus.out_dbz   = dbz_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_gf_div6_seq.sv
// +-----------------------------------------------------------------------+
// | tb_gf_div6_seq : scoreboard bench for the sequential GF(2^6) divider   |
// | Rev 1.0 : initial release                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_gf_div6_seq;
  import gf6_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf_div6_seq_if bus ();

  gf_div6_seq #(.POLY(GF_POLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] q;
    logic       dbz;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] inv_tab [64];

  // Shift-and-add reference multiply, independent of the DUT structure.
  function automatic logic [5:0] ref_mul(input logic [5:0] x, input logic [5:0] y);
    logic [6:0] sh;
    logic [5:0] r;
    sh = {1'b0, x};
    r  = '0;
    for (int i = 0; i < 6; i++) begin
      if (y[i]) r = r ^ sh[5:0];
      sh = sh << 1;
      if (sh[6]) sh = sh ^ GF_POLY;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input int stall,
                        input bit junk, output logic [5:0] q_got);
    exp_t       e;
    int         edges;
    logic [5:0] q_hold;
    logic       d_hold;
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    e.a   = a;
    e.b   = b;
    e.dbz = (b == 6'd0);
    e.q   = (b == 6'd0) ? 6'd0 : ref_mul(a, inv_tab[b]);
    sb.push_back(e);
    tick();
    edges = 1;                      // the accept edge itself is edge 1
    bus.in_valid = junk;
    bus.in_a     = 6'($urandom);
    bus.in_b     = 6'($urandom);
    while (!bus.out_valid && edges < 30) begin
      tick();
      edges++;
      bus.in_a = 6'($urandom);
      bus.in_b = 6'($urandom);
    end
    chk("latency", 32'(edges), 12);
    q_hold = bus.out_q;
    d_hold = bus.out_dbz;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_q", 32'(bus.out_q), 32'(q_hold));
      chk("hold_dbz", 32'(bus.out_dbz), 32'(d_hold));
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("busy_ready", 32'(bus.in_ready), 0);
    end
    e = sb.pop_front();
    q_got = bus.out_q;
    chk("q", 32'(bus.out_q), 32'(e.q));
    chk("dbz", 32'(bus.out_dbz), 32'(e.dbz));
    if (e.b != 6'd0) chk("q_times_b", 32'(ref_mul(bus.out_q, e.b)), 32'(e.a));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("valid_fall", 32'(bus.out_valid), 0);
    chk("q_idle_zero", 32'(bus.out_q), 0);
    chk("dbz_idle_zero", 32'(bus.out_dbz), 0);
    chk("ready_back", 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [5:0]  q;
    logic [11:0] p;
    bit          seen;

    for (int b = 0; b < 64; b++) begin
      inv_tab[b] = 6'd0;
      for (int x = 1; x < 64; x++)
        if (ref_mul(6'(b), 6'(x)) == 6'd1) inv_tab[b] = 6'(x);
    end

    // Reset with a pending offer: reset must win, nothing accepted.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 6'h05;
    bus.in_b      = 6'h07;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_q", 32'(bus.out_q), 0);
    chk("rst_out_dbz", 32'(bus.out_dbz), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;

    run_op(6'h01, 6'h02, 0, 1'b0, q);
    chk("dir_x_inverse", 32'(q), 32'h21);
    run_op(6'h2A, 6'h2A, 0, 1'b0, q);
    chk("dir_self_div", 32'(q), 32'h01);
    run_op(6'h03, 6'h01, 0, 1'b0, q);
    chk("dir_div_one", 32'(q), 32'h03);
    run_op(6'h15, 6'h00, 0, 1'b0, q);
    chk("dir_dbz_q", 32'(q), 32'h00);
    run_op(6'h00, 6'h13, 0, 1'b0, q);
    chk("dir_zero_num", 32'(q), 32'h00);

    // Long back-pressure with fresh offers hammering a busy block.
    run_op(6'h11, 6'h22, 20, 1'b1, q);
    run_op(6'h3F, 6'h05, 0, 1'b0, q);

    // Abort mid-operation with a one-cycle reset.
    bus.in_valid = 1'b1;
    bus.in_a     = 6'h09;
    bus.in_b     = 6'h03;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 0);
    run_op(6'h01, 6'h01, 0, 1'b0, q);
    chk("post_abort_q", 32'(q), 32'h01);

    // Full sweep of every (a,b) pair in a scrambled order.
    for (int idx = 0; idx < 4096; idx++) begin
      p = 12'((idx * 1237 + 555) & 12'hFFF);
      run_op(p[11:6], p[5:0], int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), q);
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
